// File: rtl/project3_pkg.sv
// project3_pkg: definitions shared by the stimulus sequencer, its interface
// and the bench.
//   seq_state_e  - sequencer state (PAUSE, RUN, HALT)
//   SCRIPT_DEPTH - number of script entries
//   ADDR_W       - script index width
//   SCRIPT       - script contents; entry i = {3'b000, i[0], 1'b0, i[2:0]}
package project3_pkg;

  localparam int SCRIPT_DEPTH = 8;
  localparam int ADDR_W       = 3;
  localparam int SCRIPT_W     = 8;

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } seq_state_e;

  // Packed so that the ROM lookup is a single indexed part-select.
  localparam logic [SCRIPT_DEPTH-1:0][SCRIPT_W-1:0] SCRIPT = {
    8'h17, 8'h06, 8'h15, 8'h04, 8'h13, 8'h02, 8'h11, 8'h00
  };

endpackage

// File: rtl/stim_sequencer_if.sv
// stim_sequencer_if: control inputs and stimulus outputs of the sequencer.
//   run    - level, 1 = automatic stepping
//   loop   - level, 1 = wrap at the last entry, 0 = halt there
//   step_n - raw active-low push-button, asynchronous to the clock
//   stim   - current script entry
//   addr   - current script index
//   tick   - one-cycle pulse when stim/addr show a new entry
//   done   - high while halted at the last entry
// master: the sequencer.  slave: whatever drives the controls and consumes
// the stimulus.
interface stim_sequencer_if #(
  parameter int DATA_W = 8
);
  logic                             run;
  logic                             loop;
  logic                             step_n;
  logic [DATA_W-1:0]                stim;
  logic [project3_pkg::ADDR_W-1:0]  addr;
  logic                             tick;
  logic                             done;

  modport master (
    input  run, loop, step_n,
    output stim, addr, tick, done
  );

  modport slave (
    output run, loop, step_n,
    input  stim, addr, tick, done
  );
endinterface

// File: rtl/key_edge_sync.sv
// key_edge_sync: conditions a raw active-low push-button.
//   clk    - sampling clock
//   reset  - synchronous active-high; all flops go to 1 (button released)
//   key_n  - raw button, asynchronous to clk
//   fall   - one-cycle pulse on a synchronized 1->0 transition
// Two synchronizer flops followed by an edge register; holding the button
// yields exactly one pulse.
module key_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic fall
);

  // sync_pipe[0..1]: synchronizer, sync_pipe[2]: previous synchronized value
  logic [2:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (reset) sync_pipe <= '1;
    else       sync_pipe <= {sync_pipe[1:0], key_n};
  end

  assign fall = sync_pipe[2] & ~sync_pipe[1];

endmodule

// File: rtl/stim_sequencer.sv
// stim_sequencer: self-running stimulus source. Walks an 8-entry script at
// one entry per CLK_DIV clocks while running, or one entry per key press
// while paused; stops at the last entry unless loop is set.
//   ADC_CLK_10 - sole clock, rising edge
//   reset      - synchronous active-high, overrides every other input
//   bus        - stim_sequencer_if master (run/loop/step_n in,
//                stim/addr/tick/done out, all outputs registered)
module stim_sequencer
  import project3_pkg::*;
#(
  parameter int CLK_DIV = 25_000_000,
  parameter int DATA_W  = 8
) (
  input  logic              ADC_CLK_10,
  input  logic              reset,
  stim_sequencer_if.master  bus
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]     PRESC_TC = PW'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(SCRIPT_DEPTH - 1);

  seq_state_e          state;
  logic [PW-1:0]       presc;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   stim_q;
  logic                tick_q;
  logic                done_q;
  logic                step_evt;
  logic [ADDR_W-1:0]   nxt_addr;
  logic                blocked;

  key_edge_sync u_step (
    .clk   (ADC_CLK_10),
    .reset (reset),
    .key_n (bus.step_n),
    .fall  (step_evt)
  );

  // Natural ADDR_W-bit wrap gives 7 -> 0 when looping.
  assign nxt_addr = addr_q + ADDR_W'(1);
  // An advance from the last entry without loop turns into a halt.
  assign blocked  = (addr_q == LAST) && !bus.loop;

  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      state  <= PAUSE;
      presc  <= '0;
      addr_q <= '0;
      stim_q <= '0;
      tick_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      unique case (state)
        PAUSE: begin
          // run takes priority over a coincident key press
          if (bus.run) begin
            state <= RUN;
            presc <= '0;
          end else if (step_evt) begin
            if (blocked) begin
              state  <= HALT;
              done_q <= 1'b1;
            end else begin
              addr_q <= nxt_addr;
              stim_q <= DATA_W'(SCRIPT[nxt_addr]);
              tick_q <= 1'b1;
            end
          end
        end
        RUN: begin
          // dropping run wins even at terminal count
          if (!bus.run) begin
            state <= PAUSE;
            presc <= '0;
          end else if (presc == PRESC_TC) begin
            presc <= '0;
            if (blocked) begin
              state  <= HALT;
              done_q <= 1'b1;
            end else begin
              addr_q <= nxt_addr;
              stim_q <= DATA_W'(SCRIPT[nxt_addr]);
              tick_q <= 1'b1;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        HALT: begin
          done_q <= 1'b1;
          if (step_evt) begin
            state  <= PAUSE;
            addr_q <= '0;
            stim_q <= DATA_W'(SCRIPT[0]);
            tick_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
        default: begin
          state <= PAUSE;
          presc <= '0;
        end
      endcase
    end
  end

  assign bus.addr = addr_q;
  assign bus.stim = stim_q;
  assign bus.tick = tick_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_stim_sequencer.sv
module tb_stim_sequencer;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] stim;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   tick_count = 0;
  int   last_tick_cyc = 0;
  exp_t exp_q[$];

  stim_sequencer_if #(.DATA_W(8)) bus ();

  stim_sequencer #(.CLK_DIV(4), .DATA_W(8)) dut (
    .ADC_CLK_10 (clk),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask

  task automatic push(input logic [2:0] a, input logic [7:0] s);
    exp_t e;
    e.addr = a;
    e.stim = s;
    exp_q.push_back(e);
  endtask

  // monitor: every tick must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.tick === 1'b1) begin
      exp_t e;
      tick_count++;
      last_tick_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_tick: addr %0d stim 0x%0h, none expected, cycle %0d", bus.addr, bus.stim, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("tick_addr", 32'(bus.addr), 32'(e.addr));
        chk("tick_stim", 32'(bus.stim), 32'(e.stim));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // waits for the next tick; returns the cycle in which it was seen
  task automatic wait_tick(input int budget, output int tc);
    int start;
    start = tick_count;
    tc = -1000;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (tick_count != start) begin
        tc = last_tick_cyc;
        return;
      end
    end
    n_checks++;
    n_errors++;
    $display("FAIL tick_timeout: no tick within %0d cycles, cycle %0d", budget, cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, tc, prev, n0;
    reset = 1'b1;
    bus.run = 1'b1;
    bus.loop = 1'b1;
    bus.step_n = 1'b1;

    // reset held 3 cycles with run=1
    cycles(3);
    chk("rst_addr", 32'(bus.addr), 0);
    chk("rst_stim", 32'(bus.stim), 0);
    chk("rst_tick", 32'(bus.tick), 0);
    chk("rst_done", 32'(bus.done), 0);

    // run, loop=1: ten ticks 4 cycles apart, including the 7 -> 0 wrap
    push(3'd1, 8'h11); push(3'd2, 8'h02); push(3'd3, 8'h13); push(3'd4, 8'h04);
    push(3'd5, 8'h15); push(3'd6, 8'h06); push(3'd7, 8'h17); push(3'd0, 8'h00);
    push(3'd1, 8'h11); push(3'd2, 8'h02);
    c = cyc;
    reset = 1'b0;
    wait_tick(20, tc);
    // RUN on the first edge after release, then 4 cycles of prescaler
    chk("first_tick_latency", 32'(tc - c), 5);
    for (int i = 0; i < 9; i++) begin
      prev = tc;
      wait_tick(20, tc);
      chk("run_tick_spacing", 32'(tc - prev), 4);
    end

    // pause with prescaler at 3: no tick; resume gives a full period
    cycles(3);
    bus.run = 1'b0;
    cycles(6);
    chk("pause_addr_held", 32'(bus.addr), 2);
    push(3'd3, 8'h13);
    c = cyc;
    bus.run = 1'b1;
    wait_tick(20, tc);
    chk("resume_tick_latency", 32'(tc - c), 5);

    // continue to addr 6, then loop=0
    push(3'd4, 8'h04); push(3'd5, 8'h15); push(3'd6, 8'h06);
    for (int i = 0; i < 3; i++) begin
      prev = tc;
      wait_tick(20, tc);
      chk("run_tick_spacing2", 32'(tc - prev), 4);
    end
    bus.loop = 1'b0;
    push(3'd7, 8'h17);
    prev = tc;
    wait_tick(20, tc);
    chk("tick_to_last_spacing", 32'(tc - prev), 4);
    cycles(3);
    chk("done_before_block", 32'(bus.done), 0);
    cycles(1);
    chk("done_after_block", 32'(bus.done), 1);
    chk("halt_addr", 32'(bus.addr), 7);
    chk("halt_stim", 32'(bus.stim), 32'h17);
    cycles(5);
    chk("done_held", 32'(bus.done), 1);
    chk("halt_addr_held", 32'(bus.addr), 7);

    // HALT exit via key press (run is ignored in HALT; lower it first)
    bus.run = 1'b0;
    cycles(2);
    chk("halt_ignores_run", 32'(bus.done), 1);
    push(3'd0, 8'h00);
    c = cyc;
    bus.step_n = 1'b0;
    wait_tick(10, tc);
    chk("halt_exit_latency", 32'(tc - c), 3);
    chk("halt_exit_done", 32'(bus.done), 0);
    cycles(10 - (cyc - c));
    bus.step_n = 1'b1;
    cycles(5);

    // single step in PAUSE, button held 10 cycles -> one advance
    bus.loop = 1'b1;
    push(3'd1, 8'h11);
    c = cyc;
    bus.step_n = 1'b0;
    wait_tick(10, tc);
    chk("step_latency", 32'(tc - c), 3);
    cycles(7);
    bus.step_n = 1'b1;
    cycles(5);
    chk("step_single_advance", 32'(bus.addr), 1);

    // bouncing button, edges away from the clock: 3 low pulses, each
    // longer than a cycle, give exactly 3 synchronized falls
    push(3'd2, 8'h02); push(3'd3, 8'h13); push(3'd4, 8'h04);
    n0 = tick_count;
    bus.step_n = 1'b0; #15;
    bus.step_n = 1'b1; #15;
    bus.step_n = 1'b0; #15;
    bus.step_n = 1'b1; #15;
    bus.step_n = 1'b0; #30;
    bus.step_n = 1'b1;
    cycles(8);
    chk("bounce_advances", 32'(tick_count - n0), 3);
    chk("bounce_addr", 32'(bus.addr), 4);

    // key press during RUN is ignored; tick timing unaffected
    push(3'd5, 8'h15); push(3'd6, 8'h06);
    c = cyc;
    bus.run = 1'b1;
    cycles(1);
    bus.step_n = 1'b0;
    cycles(3);
    bus.step_n = 1'b1;
    wait_tick(20, tc);
    chk("run_step_ignored_latency", 32'(tc - c), 5);
    prev = tc;
    wait_tick(20, tc);
    chk("run_step_ignored_spacing", 32'(tc - prev), 4);
    bus.run = 1'b0;
    cycles(6);
    chk("run_stop_addr", 32'(bus.addr), 6);

    // reset coincident with step_evt: reset values, no tick
    bus.step_n = 1'b0;
    cycles(2);
    reset = 1'b1;
    bus.step_n = 1'b1;
    cycles(1);
    chk("rst_evt_tick", 32'(bus.tick), 0);
    chk("rst_evt_addr", 32'(bus.addr), 0);
    chk("rst_evt_stim", 32'(bus.stim), 0);
    chk("rst_evt_done", 32'(bus.done), 0);
    reset = 1'b0;
    cycles(6);
    chk("post_rst_addr", 32'(bus.addr), 0);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
